uart_rx_cfg: RTL and testbench

Runtime-configurable UART receiver and successor to the fixed 8N1 receiver. It supports 5-8 data bits, none/even/odd parity, 1 or 2 stop bits, and a parametrised oversampling ratio. It applies a 3-tap majority vote per bit, reports parity, framing, break and overrun errors, and presents each frame on a valid/ready holding register. It sits between the baud-tick generator and the RX FIFO or register block.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_cfg_if.sv | 20 ++
 rtl/uart_rx_sampler.sv | 31 +++
 rtl/uart_rx_cfg.sv | 159 +++++++++++++++
 tb/tb_uart_rx_cfg.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, data-bits encoding and parity helper
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BRK_WAIT
  } rx_state_t;

  localparam logic [1:0] DB5 = 2'd0;
  localparam logic [1:0] DB6 = 2'd1;
  localparam logic [1:0] DB7 = 2'd2;
  localparam logic [1:0] DB8 = 2'd3;

  function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
    logic [2:0] idx;
    case (data_bits)
      DB5:     idx = 3'd4;
      DB6:     idx = 3'd5;
      DB7:     idx = 3'd6;
      DB8:     idx = 3'd7;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

  // Parity bit a transmitter would send; unused data MSBs must be 0.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - received-frame holding register handshake
interface uart_rx_cfg_if;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_break;
  logic       rx_overrun;

  modport master (
    output rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_break, rx_overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_break, rx_overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - line synchronizer and 3-tap majority sampler
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_clk_en,
  input  logic uart_rx,
  output logic line,
  output logic majority
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
      if (rx_clk_en) hist_q <= {hist_q[0], line};
    end
  end

  assign line = sync_q[SYNC_STAGES-1];

  // Two previous ticks plus the live tick form the vote window.
  assign majority = (hist_q[1] & hist_q[0]) | (hist_q[1] & line) | (hist_q[0] & line);

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - runtime-configurable oversampling UART receiver
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int OSR         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_clk_en,
  input  logic                 uart_rx,
  input  logic [1:0]           cfg_data_bits,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
  input  logic                 cfg_stop2,
  uart_rx_cfg_if.master        rx
);

  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] CNT_MID  = CW'(OSR / 2 + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          par_q, stop1_q;
  logic [1:0]    db_q;
  logic          par_en_q, par_odd_q, stop2_q;

  logic line, majority;
  logic at_mid, at_end, start_det, complete;
  logic stop1_val, brk, frame_err, parity_err, accept, load;

  uart_rx_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_clk_en (rx_clk_en),
    .uart_rx   (uart_rx),
    .line      (line),
    .majority  (majority)
  );

  assign at_mid = rx_clk_en && (cnt_q == CNT_MID);
  assign at_end = rx_clk_en && (cnt_q == CNT_LAST);

  // Stop bit 1 comes from the live vote in STOP1, from its stored copy in STOP2.
  assign stop1_val  = (state_q == ST_STOP1) ? majority : stop1_q;
  assign brk        = (shift_q == 8'h00) && !(par_en_q && par_q) && !stop1_val;
  assign frame_err  = !stop1_val || ((state_q == ST_STOP2) && !majority);
  assign parity_err = par_en_q && (par_q != parity_bit(shift_q, par_odd_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_det = 1'b0;
    complete  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_clk_en && !line) begin
          state_d   = ST_START;
          start_det = 1'b1;
        end
      end
      ST_START: begin
        if (at_mid && majority) state_d = ST_IDLE;
        else if (at_end)        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (at_end && (bit_idx_q == last_bit_idx(db_q)))
          state_d = par_en_q ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: begin
        if (at_end) state_d = ST_STOP1;
      end
      ST_STOP1: begin
        if (at_mid && !stop2_q) begin
          complete = 1'b1;
          state_d  = brk ? ST_BRK_WAIT : ST_IDLE;
        end else if (at_end && stop2_q) begin
          state_d = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (at_mid) begin
          complete = 1'b1;
          state_d  = brk ? ST_BRK_WAIT : ST_IDLE;
        end
      end
      ST_BRK_WAIT: begin
        if (rx_clk_en && line) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      stop1_q   <= 1'b1;
      db_q      <= DB8;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (start_det) begin
      // The detecting tick is tick 0 of the start bit.
      cnt_q     <= CW'(1);
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      db_q      <= cfg_data_bits;
      par_en_q  <= cfg_parity_en;
      par_odd_q <= cfg_parity_odd;
      stop2_q   <= cfg_stop2;
    end else if (rx_clk_en && (state_q != ST_IDLE) && (state_q != ST_BRK_WAIT)) begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      if (at_mid && (state_q == ST_DATA))   shift_q[bit_idx_q] <= majority;
      if (at_mid && (state_q == ST_PARITY)) par_q <= majority;
      if (at_mid && (state_q == ST_STOP1))  stop1_q <= majority;
      if (at_end && (state_q == ST_DATA))   bit_idx_q <= bit_idx_q + 3'd1;
    end
  end

  assign accept = rx.rx_valid && rx.rx_ready;
  assign load   = complete && (!rx.rx_valid || rx.rx_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx.rx_valid      <= 1'b0;
      rx.rx_data       <= 8'h00;
      rx.rx_parity_err <= 1'b0;
      rx.rx_frame_err  <= 1'b0;
      rx.rx_break      <= 1'b0;
      rx.rx_overrun    <= 1'b0;
    end else begin
      rx.rx_overrun <= complete && !load;
      if (load) begin
        rx.rx_valid      <= 1'b1;
        rx.rx_data       <= shift_q;
        rx.rx_parity_err <= parity_err;
        rx.rx_frame_err  <= frame_err || brk;
        rx.rx_break      <= brk;
      end else if (accept) begin
        rx.rx_valid      <= 1'b0;
        rx.rx_parity_err <= 1'b0;
        rx.rx_frame_err  <= 1'b0;
        rx.rx_break      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed self-checking bench for uart_rx_cfg
module tb_uart_rx_cfg;

  localparam int OSR = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [1:0] cfg_data_bits = 2'd3;
  logic       cfg_parity_en = 1'b0;
  logic       cfg_parity_odd = 1'b0;
  logic       cfg_stop2 = 1'b0;
  logic       rx_clk_en;
  logic [1:0] div = 2'd0;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  int frames = 0;
  int overruns = 0;
  logic [7:0] cap_data = 8'h00;
  logic       cap_par = 1'b0;
  logic       cap_frm = 1'b0;
  logic       cap_brk = 1'b0;
  int f0;
  int o0;

  uart_rx_cfg_if bus ();

  uart_rx_cfg #(.OSR(OSR), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_clk_en      (rx_clk_en),
    .uart_rx        (uart_rx),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .rx             (bus)
  );

  always #5 clk = ~clk;

  // Oversampling tick every 4 clocks.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) div <= 2'd0;
    else        div <= div + 2'd1;
  end
  assign rx_clk_en = (div == 2'd3);

  always @(posedge clk) begin
    if (rx_clk_en) tick_cnt <= tick_cnt + 1;
  end

  always @(negedge clk) begin
    if (bus.rx_valid && bus.rx_ready) begin
      frames   = frames + 1;
      cap_data = bus.rx_data;
      cap_par  = bus.rx_parity_err;
      cap_frm  = bus.rx_frame_err;
      cap_brk  = bus.rx_break;
    end
    if (bus.rx_overrun) overruns = overruns + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int target;
    target = tick_cnt + n;
    while (tick_cnt < target) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    wait_ticks(OSR);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                            input logic par_v, input logic s1, input logic two_stop,
                            input logic s2);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
    if (par_en) drive_bit(par_v);
    drive_bit(s1);
    if (two_stop) drive_bit(s2);
    uart_rx = 1'b1;
    wait_ticks(2 * OSR);
  endtask

  initial begin
    #100_000_000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_valid", bus.rx_valid, 0);
    chk("reset_data", bus.rx_data, 0);
    chk("reset_perr", bus.rx_parity_err, 0);
    chk("reset_ferr", bus.rx_frame_err, 0);
    chk("reset_brk", bus.rx_break, 0);
    chk("reset_ovr", bus.rx_overrun, 0);
    rst_n = 1'b1;
    wait_ticks(2 * OSR);

    // 8N1 0xA5
    f0 = frames;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("a5_count", frames, f0 + 1);
    chk("a5_data", cap_data, 8'hA5);
    chk("a5_perr", cap_par, 0);
    chk("a5_ferr", cap_frm, 0);
    chk("a5_brk", cap_brk, 0);

    // 7E1 with wrong parity bit, then 7O1 with the same bit
    cfg_data_bits = 2'd2; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0;
    f0 = frames;
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("7e1_count", frames, f0 + 1);
    chk("7e1_data", cap_data, 8'h41);
    chk("7e1_perr", cap_par, 1);
    chk("7e1_ferr", cap_frm, 0);
    cfg_parity_odd = 1'b1;
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("7o1_data", cap_data, 8'h41);
    chk("7o1_perr", cap_par, 0);

    // 5N2, bad then good second stop bit
    cfg_data_bits = 2'd0; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b1;
    f0 = frames;
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("5n2_bad_count", frames, f0 + 1);
    chk("5n2_bad_data", cap_data, 8'h1F);
    chk("5n2_bad_ferr", cap_frm, 1);
    chk("5n2_bad_brk", cap_brk, 0);
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("5n2_ok_count", frames, f0 + 2);
    chk("5n2_ok_ferr", cap_frm, 0);

    // False start, then a normal frame proves the receiver is idle again
    cfg_data_bits = 2'd3; cfg_stop2 = 1'b0;
    f0 = frames;
    uart_rx = 1'b0;
    wait_ticks(3);
    uart_rx = 1'b1;
    wait_ticks(3 * OSR);
    chk("false_start_count", frames, f0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("after_false_count", frames, f0 + 1);
    chk("after_false_data", cap_data, 8'h5A);

    // One-tick glitch on the middle sample of data bit 3
    f0 = frames;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    uart_rx = 1'b1; wait_ticks(8);
    uart_rx = 1'b0; wait_ticks(1);
    uart_rx = 1'b1; wait_ticks(7);
    for (int i = 4; i < 8; i++) drive_bit(1'b1);
    drive_bit(1'b1);
    wait_ticks(2 * OSR);
    chk("glitch_count", frames, f0 + 1);
    chk("glitch_data", cap_data, 8'hFF);
    chk("glitch_ferr", cap_frm, 0);

    // Break: line low for 20 bit times
    f0 = frames;
    uart_rx = 1'b0;
    wait_ticks(20 * OSR);
    chk("break_count", frames, f0 + 1);
    chk("break_brk", cap_brk, 1);
    chk("break_ferr", cap_frm, 1);
    chk("break_data", cap_data, 8'h00);
    uart_rx = 1'b1;
    wait_ticks(2 * OSR);
    chk("break_once", frames, f0 + 1);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("post_break_count", frames, f0 + 2);
    chk("post_break_data", cap_data, 8'h3C);
    chk("post_break_brk", cap_brk, 0);

    // Overrun with the consumer stalled
    bus.rx_ready = 1'b0;
    f0 = frames;
    o0 = overruns;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ovr_first_valid", bus.rx_valid, 1);
    chk("ovr_first_data", bus.rx_data, 8'h11);
    chk("ovr_none_yet", overruns, o0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ovr_held_data", bus.rx_data, 8'h11);
    chk("ovr_held_valid", bus.rx_valid, 1);
    chk("ovr_pulse_clks", overruns, o0 + 1);
    @(posedge clk);
    #1 bus.rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ovr_accept_count", frames, f0 + 1);
    chk("ovr_accept_data", cap_data, 8'h11);
    chk("ovr_valid_drop", bus.rx_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
